// File: rtl/move_stack_ctrl.sv
// Control FSM and 32 x DW storage for a move stack driven by an external 5-bit up/down counter.
// Optional macro STACK_ERR_EN builds a sticky error flag for refused pushes/pops.
module move_stack_ctrl #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic [DW-1:0] push_data,
  input  logic          pop_req,
  input  logic          clear,
  output logic          ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic          empty,
  output logic          full,
  output logic          err,
  input  logic [4:0]    count,
  input  logic          down_done,
  output logic          cntU,
  output logic          cntD,
  output logic          rst5
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CLR   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [DW-1:0] push_data_p0;
  logic [DW-1:0] mem [0:31];
  logic          idle;
  logic          take_clr;
  logic          take_pop;
  logic          take_push;

  assign empty = down_done;
  assign full  = (count == 5'd31);
  assign idle  = (state == S_IDLE);

  // Arbitration: clear beats pop beats push; a refused winner still blocks the losers.
  always_comb begin
    take_clr  = idle && clear;
    take_pop  = idle && !clear && pop_req && !empty;
    take_push = idle && !clear && !pop_req && push_req && !full;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_clr)       state_nxt = S_CLR;
        else if (take_pop)  state_nxt = S_DEC;
        else if (take_push) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = S_IDLE;
      S_DEC:   state_nxt = S_READ;
      S_READ:  state_nxt = S_IDLE;
      S_CLR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter commands are gated by rst so a reset mid-operation aborts it.
  assign ready = rst && idle;
  assign cntU  = rst && (state == S_WRITE);
  assign cntD  = rst && (state == S_DEC);
  assign rst5  = !rst || (state == S_CLR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      pop_valid    <= 1'b0;
      pop_data     <= '0;
      push_data_p0 <= '0;
    end else begin
      state     <= state_nxt;
      pop_valid <= (state == S_READ);
      if (state == S_READ) pop_data <= mem[count];
      if (take_push)       push_data_p0 <= push_data;
    end
  end

  // Storage is never reset; the count already points at the free slot during WRITE.
  always_ff @(posedge clk) begin
    if (rst && (state == S_WRITE)) mem[count] <= push_data_p0;
  end

`ifdef STACK_ERR_EN
  logic refuse;
  logic err_q;

  assign refuse = idle && !clear &&
                  ((pop_req && empty) || (!pop_req && push_req && full));

  always_ff @(posedge clk) begin
    if (!rst)          err_q <= 1'b0;
    else if (take_clr) err_q <= 1'b0;
    else if (refuse)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_move_stack_ctrl.sv
// Bench for move_stack_ctrl: models the external 5-bit counter, a reference stack and a pop scoreboard.
module tb_move_stack_ctrl;
  localparam int DW = 2;
`ifdef STACK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_req = 1'b0;
  logic          clear = 1'b0;
  logic          ready, pop_valid, empty, full, err, cntU, cntD, rst5;
  logic [DW-1:0] pop_data;
  logic [4:0]    cnt = 5'd0;
  logic          down_done;

  move_stack_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data),
    .pop_req(pop_req), .clear(clear), .ready(ready), .pop_valid(pop_valid),
    .pop_data(pop_data), .empty(empty), .full(full), .err(err),
    .count(cnt), .down_done(down_done), .cntU(cntU), .cntD(cntD), .rst5(rst5)
  );

  always #5 clk = ~clk;

  // External up/down counter
  assign down_done = (cnt == 5'd0);
  always @(posedge clk) begin
    if (rst5)      cnt <= 5'd0;
    else if (cntU) cnt <= cnt + 5'd1;
    else if (cntD) cnt <= cnt - 5'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int n_u = 0, n_d = 0, n_r = 0;

  typedef struct { logic [DW-1:0] data; int cyc; } sb_t;
  sb_t           sb[$];
  sb_t           mon_e;
  logic [DW-1:0] model[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cntU || cntD || rst5)
      check("cmd_exclusive", int'(cntU) + int'(cntD) + int'(rst5), 1);
    if (cntU) n_u++;
    if (cntD) n_d++;
    if (rst5) n_r++;
    if (pop_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pop_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pop_data", int'(pop_data), int'(mon_e.data));
        check("pop_latency_cyc", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check(name, 0, 1);
  endtask

  typedef enum int { OP_PUSH, OP_POP, OP_CLR } op_e;

  task automatic issue(input op_e op, input logic [DW-1:0] d);
    sb_t e;
    wait_ready("ready_timeout_issue");
    case (op)
      OP_PUSH: begin
        push_req = 1'b1; push_data = d;
        if (model.size() < 31) model.push_back(d);
      end
      OP_POP: begin
        pop_req = 1'b1;
        if (model.size() > 0) begin
          e.data = model.pop_back();
          e.cyc  = cyc + 3;
          sb.push_back(e);
        end
      end
      default: begin
        clear = 1'b1;
        model.delete();
      end
    endcase
    @(posedge clk); #1;
    push_req = 1'b0; pop_req = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; push_req = 1'b0; pop_req = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    check("rst_ready_low", int'(ready), 0);
    check("rst_rst5_high", int'(rst5), 1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("rst_ready", int'(ready), 1);
    check("rst_pop_valid", int'(pop_valid), 0);
    check("rst_pop_data", int'(pop_data), 0);
    check("rst_err", int'(err), 0);
    check("rst_count", int'(cnt), 0);
    model.delete();
  endtask

  typedef struct {
    op_e op; logic [DW-1:0] data; logic rdy_after;
    int count; logic empty; logic full; logic err;
    int du; int dd; int dr;
  } vec_t;
  vec_t vt[8];

  initial begin
    int u0, d0, r0;
    vt[0] = '{OP_PUSH, 2'd3, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vt[1] = '{OP_PUSH, 2'd1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vt[2] = '{OP_PUSH, 2'd2, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vt[3] = '{OP_POP,  2'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 1, 0};
    vt[4] = '{OP_POP,  2'd0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1, 0};
    vt[5] = '{OP_POP,  2'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1, 0};
    vt[6] = '{OP_POP,  2'd0, 1'b1, 0, 1'b1, 1'b0, ERR_ON, 0, 0, 0};
    vt[7] = '{OP_CLR,  2'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1};

    do_reset();

    // Table: push 3,1,2; pop three; pop on empty; clear
    for (int i = 0; i < 8; i++) begin
      wait_ready("ready_timeout_vec");
      u0 = n_u; d0 = n_d; r0 = n_r;
      issue(vt[i].op, vt[i].data);
      check($sformatf("vec%0d_ready_after", i), int'(ready), int'(vt[i].rdy_after));
      wait_ready("ready_timeout_vec");
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), int'(cnt), vt[i].count);
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].empty));
      check($sformatf("vec%0d_full", i), int'(full), int'(vt[i].full));
      check($sformatf("vec%0d_err", i), int'(err), int'(vt[i].err));
      check($sformatf("vec%0d_cntU", i), n_u - u0, vt[i].du);
      check($sformatf("vec%0d_cntD", i), n_d - d0, vt[i].dd);
      check($sformatf("vec%0d_rst5", i), n_r - r0, vt[i].dr);
    end

    // Fill to 31, refused 32nd push, then pop the 31st entry
    do_reset();
    for (int i = 1; i <= 31; i++) issue(OP_PUSH, DW'(i));
    wait_ready("ready_timeout_fill");
    check("fill_count", int'(cnt), 31);
    check("fill_full", int'(full), 1);
    u0 = n_u;
    issue(OP_PUSH, 2'd0);
    check("full_push_ready", int'(ready), 1);
    repeat (2) @(posedge clk);
    #1;
    check("full_push_count", int'(cnt), 31);
    check("full_push_full", int'(full), 1);
    check("full_push_cntU", n_u - u0, 0);
    check("full_push_err", int'(err), int'(ERR_ON));
    issue(OP_POP, 2'd0);
    wait_ready("ready_timeout_fullpop");
    repeat (3) @(posedge clk);
    #1;
    check("full_pop_count", int'(cnt), 30);
    check("full_pop_full", int'(full), 0);

    // All three requests together with count 5: clear wins
    do_reset();
    issue(OP_POP, 2'd0);
    wait_ready("ready_timeout_errpop");
    check("empty_pop_err", int'(err), int'(ERR_ON));
    for (int i = 0; i < 5; i++) issue(OP_PUSH, DW'(i + 1));
    wait_ready("ready_timeout_five");
    check("five_count", int'(cnt), 5);
    u0 = n_u; d0 = n_d; r0 = n_r;
    push_req = 1'b1; pop_req = 1'b1; clear = 1'b1; push_data = 2'd1;
    @(posedge clk); #1;
    push_req = 1'b0; pop_req = 1'b0; clear = 1'b0;
    check("clr_ready_low", int'(ready), 0);
    check("clr_rst5", int'(rst5), 1);
    @(posedge clk); #1;
    model.delete();
    check("clr_ready", int'(ready), 1);
    check("clr_count", int'(cnt), 0);
    check("clr_empty", int'(empty), 1);
    check("clr_err", int'(err), 0);
    repeat (3) @(posedge clk);
    #1;
    check("clr_rst5_pulses", n_r - r0, 1);
    check("clr_cntU", n_u - u0, 0);
    check("clr_cntD", n_d - d0, 0);

    // Reset asserted during DEC with count 4
    do_reset();
    for (int i = 0; i < 4; i++) issue(OP_PUSH, DW'(i));
    wait_ready("ready_timeout_four");
    check("four_count", int'(cnt), 4);
    d0 = n_d;
    pop_req = 1'b1;
    @(posedge clk); #1;
    pop_req = 1'b0;
    check("dec_ready_low", int'(ready), 0);
    check("dec_cntD", int'(cntD), 1);
    rst = 1'b0; #1;
    check("dec_rst_cntD", int'(cntD), 0);
    check("dec_rst_rst5", int'(rst5), 1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    model.delete();
    check("abort_count", int'(cnt), 0);
    check("abort_ready", int'(ready), 1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_cntD", n_d - d0, 0);
    check("abort_pop_valid", int'(pop_valid), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
